sorted_group_streamer: RTL and testbench

//  Consumer side of the 8-entry nibble-key sorter. Accepts one parallel bank of

---
 rtl/sort_pkg.sv | 26 ++
 rtl/sort_order_checker.sv | 29 ++
 rtl/sorted_group_streamer.sv | 116 +++++++++++
 tb/tb_sorted_group_streamer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the nibble-key sorter and its consumers: bank geometry,
// streamer state encoding and the sort-order comparison helpers.
package sort_pkg;
  localparam int N     = 8;
  localparam int W     = 8;
  localparam int KEY_W = 4;
  localparam int HI_W  = W - KEY_W;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [KEY_W-1:0] key_of(input logic [W-1:0] e);
    return e[KEY_W-1:0];
  endfunction

  function automatic logic [HI_W-1:0] hi_of(input logic [W-1:0] e);
    return e[W-1:KEY_W];
  endfunction

  // a may precede b: key ascending, ties broken by high bits descending
  function automatic logic in_order(input logic [W-1:0] a, input logic [W-1:0] b);
    return (key_of(a) < key_of(b)) ||
           ((key_of(a) == key_of(b)) && (hi_of(a) >= hi_of(b)));
  endfunction
endpackage

// File: rtl/sort_order_checker.sv
// Combinational bank inspection: flags any adjacent pair out of sort order and
// counts key groups as one plus the number of adjacent key changes.
module sort_order_checker
  import sort_pkg::*;
(
  input  logic [N*W-1:0]   load_data,
  output logic             order_err,
  output logic [CNT_W-1:0] grp_count
);
  logic [N-2:0] pair_bad;
  logic [N-2:0] key_chg;

  genvar gi;
  generate
    for (gi = 0; gi < N-1; gi++) begin : g_pair
      assign pair_bad[gi] = !in_order(load_data[gi*W +: W], load_data[(gi+1)*W +: W]);
      assign key_chg[gi]  = key_of(load_data[gi*W +: W]) != key_of(load_data[(gi+1)*W +: W]);
    end
  endgenerate

  assign order_err = |pair_bad;

  always_comb begin
    grp_count = CNT_W'(1);
    for (int i = 0; i < N-1; i++) begin
      grp_count = grp_count + CNT_W'(key_chg[i]);
    end
  end
endmodule

// File: rtl/sorted_group_streamer.sv
// Captures one sorted bank and streams it out one entry per handshake with
// key-group boundary flags; bank summary (group count, order error) is held per load.
module sorted_group_streamer
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N*W-1:0]   load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_first,
  output logic             out_last,
  output logic             out_done,
  output logic [CNT_W-1:0] grp_count,
  output logic             order_err
);
  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [W-1:0]       bank_reg [N];
  logic               order_err_reg;
  logic [CNT_W-1:0]   grp_count_reg;
  logic               chk_err;
  logic [CNT_W-1:0]   chk_grp;
  logic               load_fire, out_fire;
  logic [N-1:0]       first_vec, last_vec;

  sort_order_checker u_checker (
    .load_data (load_data),
    .order_err (chk_err),
    .grp_count (chk_grp)
  );

  assign load_ready = (state_reg == IDLE);
  assign out_valid  = (state_reg == STREAM);
  assign load_fire  = load_valid && load_ready;
  assign out_fire   = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (load_fire) begin
          state_next = STREAM;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (out_fire) begin
          if (idx_reg == IDX_W'(N-1)) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      order_err_reg <= 1'b0;
      grp_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (load_fire) begin
        order_err_reg <= chk_err;
        grp_count_reg <= chk_grp;
      end
    end
  end

  // Bank storage is pure datapath; outputs are gated by out_valid instead of reset
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bank
      always_ff @(posedge clk) begin
        if (load_fire) begin
          bank_reg[gi] <= load_data[gi*W +: W];
        end
      end

      if (gi == 0) begin : g_first_edge
        assign first_vec[gi] = 1'b1;
      end else begin : g_first_cmp
        assign first_vec[gi] = key_of(bank_reg[gi]) != key_of(bank_reg[gi-1]);
      end

      if (gi == N-1) begin : g_last_edge
        assign last_vec[gi] = 1'b1;
      end else begin : g_last_cmp
        assign last_vec[gi] = key_of(bank_reg[gi]) != key_of(bank_reg[gi+1]);
      end
    end
  endgenerate

  assign out_data  = out_valid ? bank_reg[idx_reg] : '0;
  assign out_index = idx_reg;
  assign out_first = out_valid && first_vec[idx_reg];
  assign out_last  = out_valid && last_vec[idx_reg];
  assign out_done  = out_valid && (idx_reg == IDX_W'(N-1));
  assign grp_count = grp_count_reg;
  assign order_err = order_err_reg;
endmodule

// File: tb/tb_sorted_group_streamer.sv
// Bench for sorted_group_streamer: directed banks plus random banks with random
// backpressure, checked against a rank-based reference model.
module tb_sorted_group_streamer;
  localparam int N = 8;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_valid;
  logic           load_ready;
  logic [N*W-1:0] load_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_index;
  logic           out_first;
  logic           out_last;
  logic           out_done;
  logic [3:0]     grp_count;
  logic           order_err;

  int checks = 0;
  int errors = 0;
  int bank_no = 0;

  sorted_group_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_done   (out_done),
    .grp_count  (grp_count),
    .order_err  (order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (bank %0d, t=%0t)", tag, got, exp, bank_no, $time);
    end
  endtask

  // Reference model: every entry gets a rank that must be non-decreasing along the bank
  function automatic logic [7:0] ent(input logic [63:0] b, input int i);
    return b[i*8 +: 8];
  endfunction

  function automatic int key_m(input logic [7:0] e);
    return int'(e) % 16;
  endfunction

  function automatic int rank_m(input logic [7:0] e);
    return key_m(e) * 16 + (15 - int'(e) / 16);
  endfunction

  function automatic logic exp_err(input logic [63:0] b);
    for (int i = 0; i < N-1; i++)
      if (rank_m(ent(b, i)) > rank_m(ent(b, i+1))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_grp(input logic [63:0] b);
    int n = 1;
    for (int i = 1; i < N; i++)
      if (key_m(ent(b, i)) != key_m(ent(b, i-1))) n++;
    return n;
  endfunction

  function automatic logic exp_first(input logic [63:0] b, input int k);
    if (k == 0) return 1'b1;
    return key_m(ent(b, k)) != key_m(ent(b, k-1));
  endfunction

  function automatic logic exp_last(input logic [63:0] b, input int k);
    if (k == N-1) return 1'b1;
    return key_m(ent(b, k)) != key_m(ent(b, k+1));
  endfunction

  function automatic logic [63:0] rand_bank(input int do_sort, input int kmax);
    logic [7:0] e [N];
    logic [7:0] t;
    logic [63:0] b;
    for (int i = 0; i < N; i++) begin
      e[i][3:0] = 4'($urandom_range(0, kmax));
      e[i][7:4] = 4'($urandom_range(0, 15));
    end
    if (do_sort != 0) begin
      for (int p = 0; p < N; p++)
        for (int i = 0; i < N-1; i++)
          if (rank_m(e[i]) > rank_m(e[i+1])) begin
            t = e[i]; e[i] = e[i+1]; e[i+1] = t;
          end
    end
    for (int i = 0; i < N; i++) b[i*8 +: 8] = e[i];
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_bank(input logic [63:0] b);
    int t = 0;
    bank_no++;
    while (!load_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("load_ready_idle", 64'(load_ready), 64'd1);
    load_data  = b;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = {$urandom, $urandom};
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("load_ready_busy", 64'(load_ready), 64'd0);
    chk("grp_count", 64'(grp_count), 64'(exp_grp(b)));
    chk("order_err", 64'(order_err), 64'(exp_err(b)));
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles at idx 2.
  // Returns once idx reaches stop_at transfers (N = full bank).
  task automatic stream_bank(input logic [63:0] b, input int mode, input int stop_at);
    int k = 0;
    int stall = 0;
    int guard = 0;
    logic r;
    while (k < stop_at && guard < 300) begin
      chk("valid", 64'(out_valid), 64'd1);
      chk("data", 64'(out_data), 64'(ent(b, k)));
      chk("index", 64'(out_index), 64'(k));
      chk("first", 64'(out_first), 64'(exp_first(b, k)));
      chk("last", 64'(out_last), 64'(exp_last(b, k)));
      chk("done", 64'(out_done), 64'(k == N-1));
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = !(k == 2 && stall < 3);
          if (!r) stall++;
        end
      endcase
      out_ready  = r;
      load_valid = (k < N-1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (r) begin
        $display("xfer bank %0d idx %0d data %02h", bank_no, k, ent(b, k));
        k++;
      end
      guard++;
    end
    load_valid = 1'b0;
    out_ready  = 1'($urandom_range(0, 1));
    chk("stream_timeout", 64'(guard < 300), 64'd1);
    if (stop_at == N) begin
      chk("bubble_valid", 64'(out_valid), 64'd0);
      chk("bubble_ready", 64'(load_ready), 64'd1);
      chk("hold_grp", 64'(grp_count), 64'(exp_grp(b)));
      chk("hold_err", 64'(order_err), 64'(exp_err(b)));
    end
  endtask

  initial begin
    logic [63:0] b;
    rst = 1'b0; load_valid = 1'b0; load_data = '0; out_ready = 1'b0;
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(load_ready), 64'd1);
    chk("rst_err", 64'(order_err), 64'd0);
    chk("rst_grp", 64'(grp_count), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_flags", 64'({out_first, out_last, out_done, out_index}), 64'd0);

    b = 64'hFF0A170512225231;
    load_bank(b);
    chk("grp_dir", 64'(grp_count), 64'd6);
    stream_bank(b, 0, N);
    load_bank(b);
    stream_bank(b, 2, N);

    b = 64'hFF0A170552223112;
    load_bank(b);
    chk("err_dir", 64'(order_err), 64'd1);
    stream_bank(b, 1, N);

    b = 64'h4444444444444444;
    load_bank(b);
    chk("grp_one", 64'(grp_count), 64'd1);
    chk("err_one", 64'(order_err), 64'd0);
    stream_bank(b, 1, N);

    b = 64'hFF0A170512225231;
    load_bank(b);
    stream_bank(b, 0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_ready", 64'(load_ready), 64'd1);
    chk("abort_grp", 64'(grp_count), 64'd0);
    chk("abort_err", 64'(order_err), 64'd0);
    b = rand_bank(1, 15);
    load_bank(b);
    stream_bank(b, 1, N);

    for (int i = 0; i < 24; i++) begin
      b = rand_bank((i % 3) != 0 ? 1 : 0, (i % 2) != 0 ? 3 : 15);
      load_bank(b);
      stream_bank(b, 1, N);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
